// File: rtl/uart_rx_mmio_pkg.sv
// Shared definitions for the MMIO UART receiver: FSM state type, oversampling
// constants and the status-register bit layout seen by the load path.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_MID_SAMPLE = 7;

    localparam int STAT_RX_VALID    = 0;
    localparam int STAT_FIFO_FULL   = 1;
    localparam int STAT_OVERRUN_ERR = 2;
    localparam int STAT_FRAME_ERR   = 3;
    localparam int STAT_WIDTH       = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } type_rx_state_e;

endpackage

// File: rtl/uart_rx_mmio_if.sv
// Load-path view of the receiver: pop/clear strobes in, data, status and
// interrupt out.
interface uart_rx_mmio_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
);
    logic                  rd_en;
    logic                  err_clr;
    logic [DATA_BITS-1:0]  rx_data;
    logic                  rx_valid;
    logic                  fifo_full;
    logic                  overrun_err;
    logic                  frame_err;
    logic                  rx_irq;
    logic [STAT_WIDTH-1:0] rx_status;

    modport master (
        output rd_en, err_clr,
        input  rx_data, rx_valid, fifo_full, overrun_err, frame_err, rx_irq, rx_status
    );

    modport slave (
        input  rd_en, err_clr,
        output rx_data, rx_valid, fifo_full, overrun_err, frame_err, rx_irq, rx_status
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign w_push_ok = i_push & (~o_full | i_pop);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the empty-gated output makes stale contents invisible.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/uart_rx_mmio.sv
// 16x-oversampling 8N1 UART receiver with a show-ahead receive FIFO, sticky
// overrun/frame error flags and a level interrupt for the MMIO load path.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_s_in,
    input  logic [15:0] baud_div,
    uart_rx_mmio_if.slave bus
);
    localparam int         BIT_W       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_SAMPLE  = 4'(UART_MID_SAMPLE);

    logic                  r_sync1, r_sync2, r_line_prev;
    logic [15:0]           r_tick_cnt;
    type_rx_state_e        r_state, w_state_nxt;
    logic [3:0]            r_sample_cnt, w_sample_nxt;
    logic [BIT_W-1:0]      r_bit_idx, w_bit_nxt;
    logic [DATA_BITS-1:0]  r_shift, w_shift_nxt;
    logic                  r_overrun, r_frame;
    logic                  w_fall, w_tick, w_stop_sample;
    logic                  w_stop_ok, w_frame_set, w_overrun_set;
    logic                  w_full, w_empty;
    logic [DATA_BITS-1:0]  w_head;
    logic [STAT_WIDTH-1:0] w_status;

    // Idle-high reset values keep a released reset from looking like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_line_prev <= 1'b1;
        end else begin
            r_sync1     <= uart_s_in;
            r_sync2     <= r_sync1;
            r_line_prev <= r_sync2;
        end
    end

    assign w_fall = r_line_prev & ~r_sync2;
    assign w_tick = (r_tick_cnt == baud_div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sample_cnt <= w_sample_nxt;
            r_bit_idx    <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_sample_nxt  = r_sample_cnt;
        w_bit_nxt     = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_stop_sample = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_sample_nxt = '0;
                    w_bit_nxt    = '0;
                    w_state_nxt  = START;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_sample_cnt == MID_SAMPLE) begin
                        w_sample_nxt = '0;
                        w_state_nxt  = r_sync2 ? IDLE : DATA;
                    end else begin
                        w_sample_nxt = r_sample_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_sample_cnt == LAST_SAMPLE) begin
                        w_sample_nxt = '0;
                        w_shift_nxt  = {r_sync2, r_shift[DATA_BITS-1:1]};
                        w_bit_nxt    = r_bit_idx + 1'b1;
                        if (r_bit_idx == BIT_W'(DATA_BITS - 1)) w_state_nxt = STOP;
                    end else begin
                        w_sample_nxt = r_sample_cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_sample_cnt == LAST_SAMPLE) begin
                        w_stop_sample = 1'b1;
                        w_sample_nxt  = '0;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_sample_nxt = r_sample_cnt + 4'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_stop_ok     = w_stop_sample & r_sync2;
    assign w_frame_set   = w_stop_sample & ~r_sync2;
    assign w_overrun_set = w_stop_ok & w_full & ~bus.rd_en;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_stop_ok),
        .i_din   (r_shift),
        .i_pop   (bus.rd_en),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A new error outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_overrun <= w_overrun_set | (r_overrun & ~bus.err_clr);
            r_frame   <= w_frame_set   | (r_frame   & ~bus.err_clr);
        end
    end

    always_comb begin
        w_status                   = '0;
        w_status[STAT_RX_VALID]    = ~w_empty;
        w_status[STAT_FIFO_FULL]   = w_full;
        w_status[STAT_OVERRUN_ERR] = r_overrun;
        w_status[STAT_FRAME_ERR]   = r_frame;
    end

    assign bus.rx_data     = w_head;
    assign bus.rx_valid    = ~w_empty;
    assign bus.fifo_full   = w_full;
    assign bus.overrun_err = r_overrun;
    assign bus.frame_err   = r_frame;
    assign bus.rx_irq      = ~w_empty | r_overrun | r_frame;
    assign bus.rx_status   = w_status;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio at baud_div=0 (16 clk per bit): single byte,
// glitch, frame error, overrun, full push+pop and reset mid-frame.
module tb_uart_rx_mmio;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        uart_s_in = 1'b1;
    logic [15:0] baud_div = 16'd0;
    int          n_tests = 0;
    int          n_fail  = 0;

    uart_rx_mmio_if #(.DATA_BITS(8)) bus ();

    uart_rx_mmio #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_s_in (uart_s_in),
        .baud_div  (baud_div),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 frame starting one clk after the next edge (P0). The
    // stop-sample tick falls in cycle P154..P155, so the byte is visible after P155.
    task automatic send_frame(input logic [7:0] data, input logic stop_lvl,
                              input bit chk_lat, input bit pop_at_stop);
        logic [9:0] bits;
        bits = {stop_lvl, data, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            uart_s_in = bits[i];
            repeat (16) @(posedge clk);
            #1;
        end
        uart_s_in = bits[9];
        repeat (10) @(posedge clk);
        #1;
        bus.rd_en = pop_at_stop;
        @(negedge clk);
        if (chk_lat) check("lat_before_push_valid", bus.rx_valid, 32'd0);
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        @(negedge clk);
        if (chk_lat) begin
            check("lat_after_push_valid", bus.rx_valid, 32'd1);
            check("lat_after_push_data", bus.rx_data, 32'hA5);
            check("single_overrun", bus.overrun_err, 32'd0);
            check("single_frame", bus.frame_err, 32'd0);
        end
        repeat (5) @(posedge clk);
        #1;
        uart_s_in = 1'b1;
    endtask

    task automatic pulse_rd();
        @(posedge clk); #1; bus.rd_en = 1'b1;
        @(posedge clk); #1; bus.rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; bus.err_clr = 1'b1;
        @(posedge clk); #1; bus.err_clr = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check({tag, "_valid"}, bus.rx_valid, 32'd1);
        check(tag, bus.rx_data, {24'd0, exp});
        pulse_rd();
    endtask

    initial begin
        logic [9:0] partial;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus.rx_valid, 32'd0);
        check("rst_full", bus.fifo_full, 32'd0);
        check("rst_overrun", bus.overrun_err, 32'd0);
        check("rst_frame", bus.frame_err, 32'd0);
        check("rst_irq", bus.rx_irq, 32'd0);
        check("rst_data", bus.rx_data, 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(IDLE));
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);

        // 1. Single byte with exact push latency
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        pulse_rd();
        @(negedge clk);
        check("single_pop_valid", bus.rx_valid, 32'd0);

        // 2. Glitch rejection
        @(posedge clk); #1;
        uart_s_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        uart_s_in = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("glitch_valid", bus.rx_valid, 32'd0);
        check("glitch_frame", bus.frame_err, 32'd0);
        check("glitch_overrun", bus.overrun_err, 32'd0);
        check("glitch_state", 32'(dut.r_state), 32'(IDLE));

        // 3. Frame error
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("ferr_flag", bus.frame_err, 32'd1);
        check("ferr_valid", bus.rx_valid, 32'd0);
        check("ferr_irq", bus.rx_irq, 32'd1);
        check("ferr_overrun", bus.overrun_err, 32'd0);
        pulse_clr();
        @(negedge clk);
        check("ferr_clr", bus.frame_err, 32'd0);
        check("ferr_clr_irq", bus.rx_irq, 32'd0);

        // 4. Overrun
        for (int b = 1; b <= 8; b++) send_frame(8'(b), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("ovr_full8", bus.fifo_full, 32'd1);
        check("ovr_none8", bus.overrun_err, 32'd0);
        send_frame(8'h09, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("ovr_set9", bus.overrun_err, 32'd1);
        check("ovr_full9", bus.fifo_full, 32'd1);
        for (int b = 1; b <= 8; b++) pop_check($sformatf("ovr_drain%0d", b), 8'(b));
        @(negedge clk);
        check("ovr_empty", bus.rx_valid, 32'd0);
        check("ovr_notfull", bus.fifo_full, 32'd0);
        pulse_clr();
        @(negedge clk);
        check("ovr_clr", bus.overrun_err, 32'd0);

        // 5. Push and pop in the same cycle while full
        for (int b = 1; b <= 8; b++) send_frame(8'(b), 1'b1, 1'b0, 1'b0);
        send_frame(8'h09, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("pp_overrun", bus.overrun_err, 32'd0);
        check("pp_full", bus.fifo_full, 32'd1);
        for (int b = 2; b <= 9; b++) pop_check($sformatf("pp_drain%0d", b), 8'(b));
        @(negedge clk);
        check("pp_empty", bus.rx_valid, 32'd0);

        // 6. Reset during data bit 3 of 0x55
        partial = {1'b1, 8'h55, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            uart_s_in = partial[i];
            repeat (16) @(posedge clk);
            #1;
        end
        uart_s_in = partial[4];
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        uart_s_in = 1'b1;
        @(negedge clk);
        check("mid_rst_state", 32'(dut.r_state), 32'(IDLE));
        check("mid_rst_valid", bus.rx_valid, 32'd0);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("mid_rst_data", bus.rx_data, 32'h81);
        check("mid_rst_valid1", bus.rx_valid, 32'd1);
        check("mid_rst_overrun", bus.overrun_err, 32'd0);
        check("mid_rst_frame", bus.frame_err, 32'd0);
        pulse_rd();
        @(negedge clk);
        check("mid_rst_one_byte", bus.rx_valid, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_mmio.md
# uart_rx_mmio

Serial UART receiver feeding the processor's memory-mapped I/O space, pairing with the existing transmitter on `uart_s_out`. It oversamples `uart_s_in` at 16x a programmable baud tick, deserialises 8N1 frames LSB-first, buffers bytes in a small FIFO and exposes data, status and a level interrupt to the load path.

## Interface

**Parameters**
- `DATA_BITS`, default 8: payload bits per frame.
- `FIFO_DEPTH`, default 8: receive buffer entries. Must be a power of 2, at least 2.
- `OVERSAMPLE`, default 16: ticks per bit. Fixed at 16 and not reconfigurable.

**Ports**
- `clk` in, 1: single system clock.
- `rst` in, 1: asynchronous, active-low reset.
- `uart_s_in` in, 1: serial line, idle high.
- `baud_div` in, 16: clk cycles per oversample tick, minus 1.
- `rd_en` in, 1: pop the FIFO head. Asserted by an MMIO load of the data register.
- `err_clr` in, 1: clears both sticky error flags.
- `rx_data` out, `DATA_BITS`: FIFO head (show-ahead). Value is don't-care when empty.
- `rx_valid` out, 1: FIFO not empty.
- `fifo_full` out, 1: FIFO holds `FIFO_DEPTH` entries.
- `overrun_err` out, 1: sticky. A byte was dropped because the FIFO was full.
- `frame_err` out, 1: sticky. The stop bit was sampled low.
- `rx_irq` out, 1: `rx_valid | overrun_err | frame_err`.

## Operation

**Input synchroniser**
- `uart_s_in` passes through a 2-flop synchroniser; both flops reset to 1.
- A third flop holds the previous synchronised value for falling-edge detection.

**Tick generator**
- Counter runs 0..`baud_div` and emits a 1-cycle `tick` on wrap.
- `baud_div` = 0 gives a tick every cycle.
- The counter is free-running; it is not re-phased on start-bit detection.

**FSM** (states IDLE, START, DATA, STOP; 4-bit sample counter; bit index counter)
- IDLE: on a synchronised falling edge, clear the sample counter and go to START. A constant-low line (break) does not retrigger.
- START: counts ticks. On the 8th tick (mid-bit):
  - line low: clear the counter, go to DATA;
  - line high: glitch, return to IDLE with no flags set.
- DATA: on every 16th tick, sample the line into the MSB of the shift register and shift right (LSB-first). After `DATA_BITS` samples, go to STOP.
- STOP: on the 16th tick, sample the line, then always return to IDLE.
  - High: push the byte if the FIFO is not full; otherwise set `overrun_err` and drop the byte.
  - Low: set `frame_err` and discard the byte.

**FIFO**
- Read/write pointers are `log2(FIFO_DEPTH)+1` bits; the extra MSB distinguishes full from empty.
- `rd_en` while empty is ignored with no side effect.
- Push and `rd_en` in the same cycle with the FIFO full: both happen, no overrun, occupancy unchanged.
- Push and `rd_en` in the same cycle with the FIFO empty: only the push takes effect. The new byte is visible the next cycle.

**Error flags**
- `err_clr` and a new error in the same cycle: the error wins and the flag stays set.
- `err_clr` does not affect FIFO contents.

## Timing

- **Reset values:** `rx_valid`=0, `fifo_full`=0, `overrun_err`=0, `frame_err`=0, `rx_irq`=0, `rx_data`=0. FSM in IDLE, pointers and counters at 0.
- **Reset mid-frame:** the partial byte is lost. The next falling edge after reset release starts a new frame.
- **Edge detection latency:** 3 clk after the pin falls (2 sync flops plus the edge flop).
- **Frame latency:** a pushed byte appears on `rx_data` with `rx_valid`=1 exactly 1 clk after the stop-sample tick, nominally 9.5 bit times after the start edge plus 3 clk.
- **Pop:** `rd_en` updates `rx_data` and `rx_valid` on the next clk edge.
- **Flags:** all flag updates are registered, taking effect 1 clk after the causing event.
- **Baud tolerance:** sampling at mid-bit tolerates ±(tick period + 3 clk) of skew.

## Structure

- Shared package `uart_pkg`:
  - state enum `type_rx_state_e` (IDLE, START, DATA, STOP);
  - constants `UART_OVERSAMPLE`=16 and `UART_MID_SAMPLE`=7;
  - the MMIO status-bit index constants used by the load path.
- One sub-module, `uart_rx_fifo`: parameterised synchronous show-ahead FIFO with push, pop, full and empty.
- Synchroniser, tick generator, FSM and error flags live in the top module.

## Test plan

All scenarios use `baud_div`=0, i.e. 16 clk per bit.

1. **Single byte.** Send 0xA5 (8N1). Expect `rx_data`=0xA5 and `rx_valid`=1 exactly 1 clk after the stop-sample tick, with both errors 0. After `rd_en` for 1 clk, expect `rx_valid`=0.
2. **Glitch rejection.** Drive the line low for 4 clk, then high. Expect no push, both flags 0 and the FSM back in IDLE.
3. **Frame error.** Send 0x3C with the stop bit low. Expect `frame_err`=1, `rx_valid`=0 and `rx_irq`=1. After `err_clr`, expect `frame_err`=0.
4. **Overrun.** Send bytes 0x01..0x09 with no reads. Expect `fifo_full`=1 after the 8th byte and `overrun_err`=1 after the 9th. Draining gives 0x01..0x08 in order.
5. **Simultaneous push and pop when full.** With the FIFO holding 0x01..0x08, pulse `rd_en` in the stop-sample push cycle of 0x09. Expect no overrun, and a drain order of 0x02..0x09.
6. **Reset mid-frame.** Assert `rst` low during DATA bit 3 of 0x55, then release and send 0x81. Expect exactly one byte, 0x81, and no error flags.
